data_memory_ctrl: RTL and testbench

// - Parametrised data-memory/IO controller between the RV32I MEM stage and on-chip RAM plus memory-mapped IO.
// - Adds over the current data memory: req/q_valid handshake, misaligned-access fault, 2-FF input synchronisers,

---
 rtl/data_memory_ctrl_pkg.sv | 26 ++
 rtl/data_memory_ctrl_byte_ram.sv | 19 +
 rtl/data_memory_ctrl.sv | 96 +++++++++
 tb/tb_data_memory_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_ctrl_pkg.sv
// data_memory_ctrl_pkg: access modes, region codes, response record and load extension helper
package data_memory_ctrl_pkg;
   localparam logic [1:0] MEM_BYTE = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b10;
   localparam logic [1:0] REG_RAM  = 2'b00;
   localparam logic [1:0] REG_IN   = 2'b01;
   localparam logic [1:0] REG_OUT  = 2'b10;
   localparam logic [1:0] REG_FLAG = 2'b11;
   typedef struct packed {
      logic        valid;
      logic        fault;
      logic        ram;
      logic [1:0]  off;
      logic [1:0]  mode;
      logic        uns;
      logic [31:0] io;
   } rsp_t;
   function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] off,
                                                input logic [1:0] mode, input logic uns);
      logic [31:0] sh;
      sh = raw >> {off, 3'b000};
      return mode == MEM_BYTE ? {{24{~uns & sh[7]}}, sh[7:0]} :
             mode == MEM_HALF ? {{16{~uns & sh[15]}}, sh[15:0]} : sh;
   endfunction
endpackage

// File: rtl/data_memory_ctrl_byte_ram.sv
// byte_ram: 4-lane byte-enabled synchronous RAM with registered read
module byte_ram #(
   parameter int ADDR_BITS = 10
) (
   input  logic                 clk,
   input  logic [3:0]           we,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata
);
   logic [31:0] mem_q [2**ADDR_BITS];
   logic [31:0] rdata_q;
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (we[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      rdata_q <= mem_q[addr];
   end
   assign rdata = rdata_q;
endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: RV32I data memory/IO controller with RAM, IO registers, edge flags and irq
module data_memory_ctrl
   import data_memory_ctrl_pkg::*;
#(
   parameter int RAM_ADDR_BITS = 10,
   parameter int N_OUT_REGS    = 2,
   parameter int N_IN          = 14
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    req,
   input  logic                    wren,
   input  logic [31:0]             address,
   input  logic [1:0]              mem_mode,
   input  logic                    mem_unsigned,
   input  logic [31:0]             data,
   output logic [31:0]             q,
   output logic                    q_valid,
   output logic                    fault,
   output logic                    irq,
   input  logic [N_IN-1:0]         io_input_bus,
   output logic [32*N_OUT_REGS-1:0] io_output_bus
);
   logic [1:0]              region, off;
   logic [31:0]             widx, wdata, bmask, wm, io_rd, ram_rdata;
   logic                    misalign, bad, acc, st, unused_addr;
   logic [3:0]              be, ram_we;
   logic [N_IN-1:0]         sync1_q, sync2_q, prev_q, flags_q, flags_d, mask_q, mask_d, clr;
   logic [32*N_OUT_REGS-1:0] out_q, out_d;
   rsp_t                    rsp_q, rsp_d;
   assign unused_addr = ^address[31:14];
   always_comb begin
      region   = address[13:12];
      off      = address[1:0];
      widx     = {22'b0, address[11:2]};
      misalign = (mem_mode == MEM_HALF && off[0]) || (mem_mode >= MEM_WORD && off != 2'b00);
      bad      = misalign || (region == REG_RAM && (widx >> RAM_ADDR_BITS) != 0) ||
                 (region == REG_OUT && widx >= N_OUT_REGS);
      acc      = req && !reset;
      st       = acc && !bad && wren;
      be       = mem_mode == MEM_BYTE ? 4'b0001 << off : mem_mode == MEM_HALF ? 4'b0011 << off : 4'b1111;
      wdata    = mem_mode == MEM_BYTE ? {4{data[7:0]}} : mem_mode == MEM_HALF ? {2{data[15:0]}} : data;
      bmask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      wm       = wdata & bmask;
      ram_we   = (st && region == REG_RAM) ? be : 4'b0000;
      io_rd    = '0;
      out_d    = out_q;
      for (int i = 0; i < N_OUT_REGS; i++) begin
         if (region == REG_OUT && widx == i) begin
            io_rd = out_q[32*i +: 32];
            if (st) out_d[32*i +: 32] = (out_q[32*i +: 32] & ~bmask) | wm;
         end
      end
      if (region == REG_IN && widx == 0) io_rd = 32'(sync2_q);
      if (region == REG_FLAG && widx == 0) io_rd = 32'(flags_q);
      if (region == REG_FLAG && widx == 1) io_rd = 32'(mask_q);
      // a new rising edge wins over a same-cycle clear
      clr     = (st && region == REG_FLAG && widx == 0) ? wm[N_IN-1:0] : '0;
      flags_d = (flags_q & ~clr) | (sync2_q & ~prev_q);
      mask_d  = (st && region == REG_FLAG && widx == 1) ? (mask_q & ~bmask[N_IN-1:0]) | wm[N_IN-1:0] : mask_q;
      rsp_d   = '{valid: acc && !wren, fault: acc && bad, ram: region == REG_RAM,
                  off: off, mode: mem_mode, uns: mem_unsigned, io: io_rd};
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         flags_q <= '0;
         mask_q  <= '0;
         out_q   <= '0;
         rsp_q   <= '0;
      end else begin
         sync1_q <= io_input_bus;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         flags_q <= flags_d;
         mask_q  <= mask_d;
         out_q   <= out_d;
         rsp_q   <= rsp_d;
      end
   end
   byte_ram #(.ADDR_BITS(RAM_ADDR_BITS)) u_ram (
      .clk   (clock),
      .we    (ram_we),
      .addr  (widx[RAM_ADDR_BITS-1:0]),
      .wdata (wdata),
      .rdata (ram_rdata)
   );
   assign q_valid       = rsp_q.valid;
   assign fault         = rsp_q.fault;
   assign q             = (rsp_q.valid && !rsp_q.fault) ?
                          load_extend(rsp_q.ram ? ram_rdata : rsp_q.io, rsp_q.off, rsp_q.mode, rsp_q.uns) : '0;
   assign irq           = |(flags_q & mask_q);
   assign io_output_bus = out_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed and randomized checks against a byte-addressed reference model
module tb_data_memory_ctrl;
   logic        clock = 0, reset, req, wren, mem_unsigned, q_valid, fault, irq;
   logic [31:0] address, data, q;
   logic [1:0]  mem_mode;
   logic [13:0] io_input_bus;
   logic [63:0] io_output_bus;
   int          passed = 0, total = 0, fails = 0;
   logic [7:0]  mem_b [64];
   logic [7:0]  ob [8];
   logic [13:0] m_flags, m_mask, m_in;

   data_memory_ctrl dut (
      .clock(clock), .reset(reset), .req(req), .wren(wren), .address(address),
      .mem_mode(mem_mode), .mem_unsigned(mem_unsigned), .data(data), .q(q),
      .q_valid(q_valid), .fault(fault), .irq(irq), .io_input_bus(io_input_bus),
      .io_output_bus(io_output_bus)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [1:0] m,
                      input logic u, input logic [31:0] d);
      req = r; wren = w; address = a; mem_mode = m; mem_unsigned = u; data = d;
      @(posedge clock);
      @(negedge clock);
   endtask

   function automatic logic [7:0] gb(input logic [31:0] a);
      logic [31:0] w;
      int ln;
      w  = {22'b0, a[11:2]};
      ln = int'(a[1:0]);
      case (a[13:12])
         2'b00:   return mem_b[a[5:0]];
         2'b01:   return w == 0 ? 8'(32'(m_in) >> (8*ln)) : 8'h00;
         2'b10:   return ob[a[2:0]];
         default: return w == 0 ? 8'(32'(m_flags) >> (8*ln)) : w == 1 ? 8'(32'(m_mask) >> (8*ln)) : 8'h00;
      endcase
   endfunction

   task automatic pb(input logic [31:0] a, input logic [7:0] b);
      logic [31:0] w;
      int ln;
      w  = {22'b0, a[11:2]};
      ln = int'(a[1:0]);
      case (a[13:12])
         2'b00: mem_b[a[5:0]] = b;
         2'b10: ob[a[2:0]] = b;
         2'b11: begin
            if (w == 0) m_flags = m_flags & ~14'(32'(b) << (8*ln));
            else if (w == 1) m_mask = 14'((32'(m_mask) & ~(32'hff << (8*ln))) | (32'(b) << (8*ln)));
         end
         default: ;
      endcase
   endtask

   function automatic logic [63:0] out_model();
      logic [63:0] v;
      v = '0;
      for (int k = 0; k < 8; k++) v |= 64'(ob[k]) << (8*k);
      return v;
   endfunction

   initial begin
      int k;
      reset = 1; io_input_bus = '0;
      cyc(0, 0, 0, 2'b00, 0, 0);
      cyc(0, 0, 0, 2'b00, 0, 0);
      chk("rst_q_valid", 64'(q_valid), 64'(0));
      chk("rst_q", 64'(q), 64'(0));
      chk("rst_fault", 64'(fault), 64'(0));
      chk("rst_irq", 64'(irq), 64'(0));
      chk("rst_out", io_output_bus, 64'(0));
      reset = 0;
      cyc(1, 1, 32'h4, 2'b10, 0, 32'hDEADBEEF);
      chk("st_q_valid", 64'(q_valid), 64'(0));
      chk("st_fault", 64'(fault), 64'(0));
      cyc(1, 0, 32'h7, 2'b00, 1, 0);
      chk("lbu_valid", 64'(q_valid), 64'(1));
      chk("lbu_q", 64'(q), 64'h000000DE);
      cyc(1, 0, 32'h7, 2'b00, 0, 0);
      chk("lb_q", 64'(q), 64'hFFFFFFDE);
      cyc(0, 0, 0, 2'b00, 0, 0);
      chk("idle_valid", 64'(q_valid), 64'(0));
      cyc(1, 1, 32'h0, 2'b10, 0, 32'h11223344);
      cyc(1, 1, 32'h3, 2'b01, 0, 32'h1234);
      chk("mis_st_fault", 64'(fault), 64'(1));
      chk("mis_st_valid", 64'(q_valid), 64'(0));
      cyc(1, 0, 32'h0, 2'b10, 0, 0);
      chk("reload_fault", 64'(fault), 64'(0));
      chk("reload_q", 64'(q), 64'h11223344);
      cyc(1, 0, 32'h2, 2'b10, 0, 0);
      chk("mis_ld_fault", 64'(fault), 64'(1));
      chk("mis_ld_valid", 64'(q_valid), 64'(1));
      chk("mis_ld_q", 64'(q), 64'(0));
      cyc(1, 1, 32'h8, 2'b10, 0, 32'hCAFEF00D);
      cyc(1, 0, 32'h0, 2'b10, 0, 0);
      chk("b2b0", {31'b0, q_valid, q}, {32'h1, 32'h11223344});
      cyc(1, 0, 32'h4, 2'b10, 0, 0);
      chk("b2b1", {31'b0, q_valid, q}, {32'h1, 32'hDEADBEEF});
      cyc(1, 0, 32'h8, 2'b10, 0, 0);
      chk("b2b2", {31'b0, q_valid, q}, {32'h1, 32'hCAFEF00D});
      cyc(0, 0, 0, 2'b00, 0, 0);
      chk("b2b_end", 64'({q_valid, fault}), 64'(0));
      cyc(1, 1, 32'h2001, 2'b00, 0, 32'h123456AB);
      chk("out_byte", io_output_bus, 64'h0000AB00);
      cyc(1, 0, 32'h2000, 2'b10, 0, 0);
      chk("out_read", 64'(q), 64'h0000AB00);
      cyc(1, 1, 32'h200C, 2'b01, 0, 32'hFFFF);
      chk("out_oob_fault", 64'(fault), 64'(1));
      chk("out_oob_bus", io_output_bus, 64'h0000AB00);
      cyc(1, 1, 32'h3004, 2'b10, 0, 32'h8);
      io_input_bus = 14'h8;
      k = 0;
      while (!irq && k < 6) begin
         cyc(0, 0, 0, 2'b00, 0, 0);
         k++;
      end
      chk("edge_irq", 64'(irq), 64'(1));
      chk("edge_latency", 64'(k <= 3), 64'(1));
      cyc(1, 0, 32'h3000, 2'b10, 0, 0);
      chk("flags_read", 64'(q), 64'h8);
      cyc(1, 1, 32'h3000, 2'b10, 0, 32'h8);
      chk("w1c_irq", 64'(irq), 64'(0));
      cyc(1, 0, 32'h3000, 2'b10, 0, 0);
      chk("w1c_flags", 64'(q), 64'h0);
      cyc(1, 0, 32'h0, 2'b10, 0, 0);
      reset = 1;
      cyc(1, 0, 32'h4, 2'b10, 0, 0);
      chk("mid_rst_valid", 64'(q_valid), 64'(0));
      chk("mid_rst_q", 64'(q), 64'(0));
      chk("mid_rst_out", io_output_bus, 64'(0));
      reset = 0;
      cyc(1, 0, 32'h3000, 2'b10, 0, 0);
      chk("mid_rst_flags", 64'(q), 64'(0));
      cyc(1, 0, 32'h3004, 2'b10, 0, 0);
      chk("mid_rst_mask", 64'(q), 64'(0));

      m_in = 14'($urandom) | 14'h1;
      reset = 1;
      io_input_bus = m_in;
      cyc(0, 0, 0, 2'b00, 0, 0);
      reset = 0;
      repeat (4) cyc(0, 0, 0, 2'b00, 0, 0);
      m_flags = m_in;
      m_mask  = '0;
      for (int j = 0; j < 8; j++) ob[j] = 8'h00;
      for (int j = 0; j < 16; j++) begin
         logic [31:0] d;
         d = $urandom;
         cyc(1, 1, 32'(4*j), 2'b10, 0, d);
         for (int b = 0; b < 4; b++) pb(32'(4*j + b), d[8*b +: 8]);
      end
      for (int n = 0; n < 300; n++) begin
         logic        r, w, u, bad;
         logic [1:0]  m;
         logic [31:0] a, d, eq;
         int          sz, rg;
         r  = $urandom_range(0, 7) != 0;
         w  = $urandom_range(0, 2) == 0;
         u  = 1'($urandom_range(0, 1));
         m  = 2'($urandom_range(0, 2));
         d  = $urandom;
         rg = int'($urandom_range(0, 3));
         a  = rg == 0 ? 32'($urandom_range(0, 63)) : rg == 1 ? 32'h1000 + 32'($urandom_range(0, 7)) :
              rg == 2 ? 32'h2000 + 32'($urandom_range(0, 15)) : 32'h3000 + 32'($urandom_range(0, 11));
         sz  = 1 << m;
         bad = (m == 2'b01 && a[0]) || (m == 2'b10 && a[1:0] != 2'b00) || (a[13:12] == 2'b10 && a[11:2] >= 2);
         eq  = '0;
         if (r && !w && !bad) begin
            for (int j = 0; j < sz; j++) eq |= 32'(gb(a + 32'(j))) << (8*j);
            if (!u && sz < 4 && eq[8*sz-1]) eq |= ~((32'h1 << (8*sz)) - 32'h1);
         end
         cyc(r, w, a, m, u, d);
         if (r && w && !bad)
            for (int j = 0; j < sz; j++) pb(a + 32'(j), d[8*j +: 8]);
         chk("rnd_valid", 64'(q_valid), 64'(r && !w));
         chk("rnd_fault", 64'(fault), 64'(r && bad));
         if (r && !w) chk("rnd_q", 64'(q), 64'(eq));
         chk("rnd_irq", 64'(irq), 64'(|(m_flags & m_mask)));
         chk("rnd_out", io_output_bus, out_model());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
